// File: rtl/wt_cache_pkg.sv
// Shared constants and the saturating counter step for the wt_dcache signature
// hit counter table.
package wt_cache_pkg;

  localparam int unsigned SHCT_SIG_WIDTH = 14;
  localparam int unsigned SHCT_CNT_WIDTH = 2;

  // Widest counter the helper supports; narrower counters are zero-extended.
  localparam int unsigned SHCT_CNT_MAX_W = 4;

  typedef logic [SHCT_CNT_MAX_W-1:0] shct_cnt_t;

  // One saturating step: +1 for inc, -1 for dec, nothing when both or neither.
  function automatic shct_cnt_t shct_sat_step(input shct_cnt_t val,
                                              input logic      inc,
                                              input logic      dec,
                                              input shct_cnt_t max_val);
    shct_cnt_t res;
    res = val;
    if (inc && !dec) begin
      if (val != max_val) res = val + shct_cnt_t'(1);
    end else if (dec && !inc) begin
      if (val != '0) res = val - shct_cnt_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/wt_dcache_shct.sv
// Signature hit counter table: per-signature saturating reuse counters with an
// init sweep, hit/evict training and a one-cycle forwarded lookup.
module wt_dcache_shct
  import wt_cache_pkg::*;
#(
  parameter int unsigned SigWidth = SHCT_SIG_WIDTH,
  parameter int unsigned CntWidth = SHCT_CNT_WIDTH,
  parameter int unsigned CntInit  = 2**CntWidth - 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                busy_o,
  input  logic                lkp_req_i,
  input  logic [SigWidth-1:0] lkp_sig_i,
  output logic                lkp_gnt_o,
  output logic                lkp_vld_o,
  output logic [CntWidth-1:0] lkp_cnt_o,
  output logic                lkp_distant_o,
  input  logic                hit_i,
  input  logic [SigWidth-1:0] hit_sig_i,
  input  logic                evict_i,
  input  logic [SigWidth-1:0] evict_sig_i,
  input  logic                evict_reused_i
);

  localparam int unsigned Depth = 2**SigWidth;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam shct_cnt_t             CntMax  = shct_cnt_t'(2**CntWidth - 1);
  localparam logic [CntWidth-1:0]   InitVal = CntInit[CntWidth-1:0];

  logic [0:0]          state_q, state_d;
  logic [SigWidth-1:0] sweep_addr_q, sweep_addr_d;
  logic                lkp_vld_q, lkp_vld_d;
  logic [CntWidth-1:0] lkp_cnt_q, lkp_cnt_d;
  logic [CntWidth-1:0] shct_q [Depth];

  logic                ready;
  logic                sweep_we;
  logic                upd_en;
  logic                same_sig;
  logic                hit_we;
  logic                ev_we;
  logic [CntWidth-1:0] hit_data;
  logic [CntWidth-1:0] ev_data;
  logic                lkp_acc;
  logic [CntWidth-1:0] lkp_fwd;
  shct_cnt_t           hit_step;
  shct_cnt_t           ev_step;

  function automatic shct_cnt_t widen(input logic [CntWidth-1:0] v);
    shct_cnt_t w;
    w = '0;
    w[CntWidth-1:0] = v;
    return w;
  endfunction

  assign ready = (state_q == ST_READY);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    sweep_we     = 1'b0;
    if (flush_i) begin
      state_d      = ST_INIT;
      sweep_addr_d = '0;
    end else if (!ready) begin
      sweep_we     = 1'b1;
      sweep_addr_d = sweep_addr_q + 1'b1;
      if (sweep_addr_q == '1) state_d = ST_READY;
    end
  end

  // A hit and an evict on the same signature merge into one write so neither is lost.
  always_comb begin
    upd_en   = ready && !flush_i;
    same_sig = (hit_sig_i == evict_sig_i);
    hit_we   = upd_en && hit_i;
    ev_we    = upd_en && evict_i && !evict_reused_i && !(hit_i && same_sig);
    hit_step = shct_sat_step(widen(shct_q[hit_sig_i]), 1'b1,
                             evict_i && same_sig && !evict_reused_i, CntMax);
    ev_step  = shct_sat_step(widen(shct_q[evict_sig_i]), 1'b0, 1'b1, CntMax);
    hit_data = hit_step[CntWidth-1:0];
    ev_data  = ev_step[CntWidth-1:0];
  end

  // Lookups see this cycle's updates so a result is never one training step stale.
  always_comb begin
    lkp_acc = lkp_gnt_o && lkp_req_i;
    if (hit_we && (hit_sig_i == lkp_sig_i)) begin
      lkp_fwd = hit_data;
    end else if (ev_we && (evict_sig_i == lkp_sig_i)) begin
      lkp_fwd = ev_data;
    end else begin
      lkp_fwd = shct_q[lkp_sig_i];
    end
    lkp_vld_d = lkp_acc;
    lkp_cnt_d = lkp_acc ? lkp_fwd : lkp_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_INIT;
      sweep_addr_q <= '0;
      lkp_vld_q    <= 1'b0;
      lkp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      lkp_vld_q    <= lkp_vld_d;
      lkp_cnt_q    <= lkp_cnt_d;
    end
  end

  // NOTE: the table has no reset; the init sweep is what defines its contents.
  always_ff @(posedge clk_i) begin
    if (sweep_we) shct_q[sweep_addr_q] <= InitVal;
    if (hit_we)   shct_q[hit_sig_i]    <= hit_data;
    if (ev_we)    shct_q[evict_sig_i]  <= ev_data;
  end

  assign busy_o        = !ready;
  assign lkp_gnt_o     = ready && !flush_i;
  assign lkp_vld_o     = lkp_vld_q;
  assign lkp_cnt_o     = lkp_cnt_q;
  assign lkp_distant_o = (lkp_cnt_q == '0);

endmodule

// File: tb/tb_wt_dcache_shct.sv
// Randomized and directed bench for wt_dcache_shct with a queue-based scoreboard
// and an array reference model of the counter table.
module tb_wt_dcache_shct;

  localparam int SW   = 4;
  localparam int CW   = 2;
  localparam int N    = 16;
  localparam int MAXV = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          busy_o;
  logic          lkp_req_i;
  logic [SW-1:0] lkp_sig_i;
  logic          lkp_gnt_o;
  logic          lkp_vld_o;
  logic [CW-1:0] lkp_cnt_o;
  logic          lkp_distant_o;
  logic          hit_i;
  logic [SW-1:0] hit_sig_i;
  logic          evict_i;
  logic [SW-1:0] evict_sig_i;
  logic          evict_reused_i;

  always #5 clk_i = ~clk_i;

  wt_dcache_shct #(.SigWidth(SW), .CntWidth(CW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .lkp_req_i      (lkp_req_i),
    .lkp_sig_i      (lkp_sig_i),
    .lkp_gnt_o      (lkp_gnt_o),
    .lkp_vld_o      (lkp_vld_o),
    .lkp_cnt_o      (lkp_cnt_o),
    .lkp_distant_o  (lkp_distant_o),
    .hit_i          (hit_i),
    .hit_sig_i      (hit_sig_i),
    .evict_i        (evict_i),
    .evict_sig_i    (evict_sig_i),
    .evict_reused_i (evict_reused_i)
  );

  int tests = 0;
  int fails = 0;
  int model [N];
  int sweep_left = 0;
  int exp_q [$];
  bit mon_en = 1'b0;
  int last_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  // One clock cycle of stimulus; the model advances by the same rules the table obeys.
  task automatic do_cycle(input bit req, input int lsig, input bit hit, input int hsig,
                          input bit ev, input int esig, input bit reused, input bit flush);
    bit ready;
    lkp_req_i      = req;
    lkp_sig_i      = SW'(lsig);
    hit_i          = hit;
    hit_sig_i      = SW'(hsig);
    evict_i        = ev;
    evict_sig_i    = SW'(esig);
    evict_reused_i = reused;
    flush_i        = flush;
    @(negedge clk_i);
    ready = (sweep_left == 0);
    check("busy", int'(busy_o), int'(!ready));
    check("gnt", int'(lkp_gnt_o), int'(ready && !flush));
    if (flush) begin
      sweep_left = N;
    end else if (!ready) begin
      model[N - sweep_left] = MAXV;
      sweep_left--;
    end else begin
      if (hit && ev && hsig == esig) begin
        model[hsig] = clamp(model[hsig] + 1 - (reused ? 0 : 1));
      end else begin
        if (hit) model[hsig] = clamp(model[hsig] + 1);
        if (ev && !reused) model[esig] = clamp(model[esig] - 1);
      end
      if (req) exp_q.push_back(model[lsig]);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input int sig);
    do_cycle(1, sig, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic evict(input int sig, input bit reused);
    do_cycle(0, 0, 0, 0, 1, sig, reused, 0);
  endtask

  // Monitor: every valid result must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    int e;
    if (mon_en) begin
      if (lkp_vld_o) begin
        if (exp_q.size() == 0) begin
          check("vld_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("lkp_cnt", int'(lkp_cnt_o), e);
          check("lkp_distant", int'(lkp_distant_o), int'(e == 0));
          last_cnt = e;
        end
      end else begin
        check("cnt_hold", int'(lkp_cnt_o), last_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 0; lkp_req_i = 0; lkp_sig_i = '0; hit_i = 0; hit_sig_i = '0;
    evict_i = 0; evict_sig_i = '0; evict_reused_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", int'(busy_o), 1);
    check("rst_vld", int'(lkp_vld_o), 0);
    check("rst_cnt", int'(lkp_cnt_o), 0);
    check("rst_distant", int'(lkp_distant_o), 1);
    check("rst_gnt", int'(lkp_gnt_o), 0);

    rst_ni     = 1'b1;
    sweep_left = N;
    last_cnt   = 0;
    mon_en     = 1'b1;

    // Exactly N busy cycles, then every entry reads the init value.
    repeat (N) idle();
    idle();
    for (int s = 0; s < N; s++) lookup(s);

    // Decrement to zero and saturate there.
    repeat (4) evict(5, 0);
    lookup(5);
    evict(5, 0);
    lookup(5);

    // Same-signature hit+evict merge.
    repeat (2) evict(7, 0);
    do_cycle(1, 7, 1, 7, 1, 7, 0, 0);
    do_cycle(1, 7, 1, 7, 1, 7, 1, 0);
    lookup(7);

    // Same-cycle hit forwarded into the lookup.
    repeat (2) evict(2, 0);
    do_cycle(1, 2, 1, 2, 0, 0, 0, 0);
    lookup(2);

    // Independent updates on different signatures; hit saturates at max.
    do_cycle(0, 0, 1, 4, 1, 6, 0, 0);
    lookup(4);
    lookup(6);
    do_cycle(1, 6, 1, 6, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      do_cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, N-1)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, N-1)),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, N-1)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 2*N && sweep_left > 0; i++) idle();
    evict(3, 0);
    lookup(3);

    // Flush from READY, then flush again when the sweep reaches address 9.
    do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (9) idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (N) do_cycle(1, 3, 0, 0, 1, 3, 0, 0);
    idle();
    lookup(3);

    repeat (3) idle();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
